// File: rtl/flags_ctrl_pkg.sv
// Shared types and constants for the flags-register write controller.
package flags_ctrl_pkg;
  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FROZEN = 2'd2
  } fa_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or above rr_ptr, wrapping.
// Zero latency; gnt_vld low when no request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_vld && req[cand]) begin
        gnt_vld       = 1'b1;
        gnt_oh[cand]  = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/flags_write_arbiter.sv
// Round-robin arbiter merging masked flag updates into the flags register; grant and write one cycle after req.
// freeze stalls all grants; optional FLAGS_SAVE_RESTORE_EN adds interrupt save/restore of the flags.
module flags_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int FLAG_W  = flags_ctrl_pkg::FLAG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*FLAG_W-1:0]   req_flags,
  input  logic [NUM_REQ*FLAG_W-1:0]   req_mask,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        flags_we,
  output logic [FLAG_W-1:0]           flags_d,
  output logic [FLAG_W-1:0]           cur_flags
`ifdef FLAGS_SAVE_RESTORE_EN
  ,
  input  logic                        save,
  input  logic                        restore
`endif
);
  import flags_ctrl_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  fa_state_t            state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 flags_we_q, flags_we_d;
  logic [FLAG_W-1:0]    flags_d_q, flags_d_d;
  logic [FLAG_W-1:0]    cur_flags_q, cur_flags_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic [FLAG_W-1:0]    sel_flags, sel_mask, merged;

`ifdef FLAGS_SAVE_RESTORE_EN
  logic [FLAG_W-1:0]    saved_flags_q, saved_flags_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    sel_flags = '0;
    sel_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i]) begin
        sel_flags = req_flags[i*FLAG_W +: FLAG_W];
        sel_mask  = req_mask[i*FLAG_W +: FLAG_W];
      end
    end
  end

  // Merge against our own copy so back-to-back writes never read a stale register.
  assign merged = (cur_flags_q & ~sel_mask) | (sel_flags & sel_mask);

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    flags_we_d  = 1'b0;
    flags_d_d   = flags_d_q;
    cur_flags_d = cur_flags_q;
    rr_ptr_d    = rr_ptr_q;
    if (freeze) begin
      state_d = FROZEN;
    end
`ifdef FLAGS_SAVE_RESTORE_EN
    else if (restore) begin
      state_d     = WRITE;
      flags_we_d  = 1'b1;
      flags_d_d   = saved_flags_q;
      cur_flags_d = saved_flags_q;
    end
`endif
    else if (arb_vld) begin
      state_d     = WRITE;
      gnt_d       = arb_oh;
      flags_we_d  = 1'b1;
      flags_d_d   = merged;
      cur_flags_d = merged;
      rr_ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end else begin
      state_d = IDLE;
    end
  end

`ifdef FLAGS_SAVE_RESTORE_EN
  // Save captures the pre-restore value when both fire together.
  assign saved_flags_d = save ? cur_flags_q : saved_flags_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      flags_we_q    <= 1'b0;
      flags_d_q     <= '0;
      cur_flags_q   <= '0;
      rr_ptr_q      <= '0;
`ifdef FLAGS_SAVE_RESTORE_EN
      saved_flags_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      flags_we_q    <= flags_we_d;
      flags_d_q     <= flags_d_d;
      cur_flags_q   <= cur_flags_d;
      rr_ptr_q      <= rr_ptr_d;
`ifdef FLAGS_SAVE_RESTORE_EN
      saved_flags_q <= saved_flags_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign flags_we  = flags_we_q;
  assign flags_d   = flags_d_q;
  assign cur_flags = cur_flags_q;

endmodule

// File: tb/tb_flags_write_arbiter.sv
// Bench for flags_write_arbiter: directed vector table, corner sequences and a randomized model check.
module tb_flags_write_arbiter;
  localparam int N  = 3;
  localparam int FW = 4;
`ifdef FLAGS_SAVE_RESTORE_EN
  localparam bit SR = 1'b1;
`else
  localparam bit SR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            freeze = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*FW-1:0] req_flags = '0;
  logic [N*FW-1:0] req_mask = '0;
  logic            save = 1'b0;
  logic            restore = 1'b0;
  logic [N-1:0]    gnt;
  logic            flags_we;
  logic [FW-1:0]   flags_d;
  logic [FW-1:0]   cur_flags;

  int checks = 0;
  int errors = 0;

  flags_write_arbiter #(.NUM_REQ(N), .FLAG_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .req       (req),
    .req_flags (req_flags),
    .req_mask  (req_mask),
    .gnt       (gnt),
    .flags_we  (flags_we),
    .flags_d   (flags_d),
    .cur_flags (cur_flags)
`ifdef FLAGS_SAVE_RESTORE_EN
    ,
    .save      (save),
    .restore   (restore)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            fz;
    logic [N-1:0]    rq;
    logic [N*FW-1:0] fl;
    logic [N*FW-1:0] mk;
    logic [N-1:0]    e_gnt;
    logic            e_we;
    logic [FW-1:0]   e_fd;
  } vec_t;

  vec_t vecs[10];

  // Behavioural model state
  logic [FW-1:0] m_cur, m_saved;
  int            m_ptr;
  logic [N-1:0]  exp_gnt;
  logic          exp_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic fz, input logic [N-1:0] rq,
                        input logic [N*FW-1:0] fl, input logic [N*FW-1:0] mk);
    freeze    = fz;
    req       = rq;
    req_flags = fl;
    req_mask  = mk;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, '0, '0);
    save    = 1'b0;
    restore = 1'b0;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    m_cur   = '0;
    m_saved = '0;
    m_ptr   = 0;
  endtask

  // Model: one arbitration decision per cycle, computed straight from the rules.
  task automatic model_step(input logic fz, input logic [N-1:0] rq, input logic [N*FW-1:0] fl,
                            input logic [N*FW-1:0] mk, input logic sv, input logic rs);
    logic [FW-1:0] old_cur;
    int w;
    old_cur = m_cur;
    exp_gnt = '0;
    exp_we  = 1'b0;
    w       = -1;
    if (fz) begin
      exp_we = 1'b0;
    end else if (rs && SR) begin
      m_cur  = m_saved;
      exp_we = 1'b1;
    end else if (rq != '0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      for (int b = 0; b < FW; b++)
        if (mk[w*FW + b]) m_cur[b] = fl[w*FW + b];
      exp_gnt[w] = 1'b1;
      exp_we     = 1'b1;
      m_ptr      = (w + 1) % N;
    end
    if (sv && SR) m_saved = old_cur;
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] eg, input logic ew, input logic [FW-1:0] ef);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".we"}, 32'(flags_we), 32'(ew));
    chk({tag, ".flags_d"}, 32'(flags_d), 32'(ef));
    chk({tag, ".cur"}, 32'(cur_flags), 32'(ef));
  endtask

  logic [N-1:0] fair_seq[6];

  initial begin
    vecs[0] = '{1'b0, 3'b001, {4'b0000, 4'b0000, 4'b1010}, {4'b0000, 4'b0000, 4'b1111}, 3'b001, 1'b1, 4'b1010};
    vecs[1] = '{1'b0, 3'b010, {4'b0000, 4'b0101, 4'b0000}, {4'b0000, 4'b0011, 4'b0000}, 3'b010, 1'b1, 4'b1001};
    vecs[2] = '{1'b0, 3'b000, 12'h000, 12'h000, 3'b000, 1'b0, 4'b1001};
    vecs[3] = '{1'b0, 3'b111, {4'b1111, 4'b1111, 4'b1111}, {4'b0100, 4'b1111, 4'b1111}, 3'b100, 1'b1, 4'b1101};
    vecs[4] = '{1'b0, 3'b110, 12'h000, {4'b0000, 4'b0001, 4'b0000}, 3'b010, 1'b1, 4'b1100};
    vecs[5] = '{1'b1, 3'b111, 12'hfff, 12'hfff, 3'b000, 1'b0, 4'b1100};
    vecs[6] = '{1'b0, 3'b011, {4'b0000, 4'b0000, 4'b1111}, 12'h000, 3'b001, 1'b1, 4'b1100};
    vecs[7] = '{1'b0, 3'b001, {4'b0000, 4'b0000, 4'b0011}, {4'b0000, 4'b0000, 4'b1111}, 3'b001, 1'b1, 4'b0011};
    vecs[8] = '{1'b0, 3'b101, {4'b1111, 4'b0000, 4'b0000}, {4'b1111, 4'b0000, 4'b0000}, 3'b100, 1'b1, 4'b1111};
    vecs[9] = '{1'b0, 3'b001, 12'h000, {4'b0000, 4'b0000, 4'b0110}, 3'b001, 1'b1, 4'b1001};
    fair_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state while rst is held
    #2;
    chk_all("reset", '0, 1'b0, '0);
    do_reset();

    foreach (vecs[i]) begin
      set_in(vecs[i].fz, vecs[i].rq, vecs[i].fl, vecs[i].mk);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_we, vecs[i].e_fd);
    end

    // Fairness: all three requesting, held
    do_reset();
    set_in(1'b0, 3'b111, 12'h000, 12'h000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fair%0d.gnt", i), 32'(gnt), 32'(fair_seq[i]));
    end

    // Freeze holds off grants; req0 wins on release
    do_reset();
    set_in(1'b1, 3'b011, {4'b0000, 4'b0000, 4'b0110}, {4'b0000, 4'b0000, 4'b1111});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz%0d.gnt", i), 32'(gnt), 32'(0));
      chk($sformatf("frz%0d.we", i), 32'(flags_we), 32'(0));
    end
    freeze = 1'b0;
    tick();
    chk_all("frz_rel", 3'b001, 1'b1, 4'b0110);

    // Reset during a write clears outputs immediately and nothing is written later
    set_in(1'b0, 3'b010, {4'b0000, 4'b1111, 4'b0000}, {4'b0000, 4'b1111, 4'b0000});
    tick();
    chk("midrst.pre_gnt", 32'(gnt), 32'(3'b010));
    rst = 1'b1;
    #1;
    chk_all("midrst", '0, 1'b0, '0);
    set_in(1'b0, '0, '0, '0);
    tick();
    rst = 1'b0;
    m_cur = '0; m_saved = '0; m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst%0d.we", i), 32'(flags_we), 32'(0));
    end

`ifdef FLAGS_SAVE_RESTORE_EN
    do_reset();
    set_in(1'b0, 3'b001, {8'h00, 4'b1100}, {8'h00, 4'b1111});
    tick();
    set_in(1'b0, 3'b000, '0, '0);
    save = 1'b1;
    tick();
    save = 1'b0;
    set_in(1'b0, 3'b001, {8'h00, 4'b0011}, {8'h00, 4'b1111});
    tick();
    chk("sr.cur_pre", 32'(cur_flags), 32'(4'b0011));
    restore = 1'b1;
    tick();
    chk_all("sr.restore", 3'b000, 1'b1, 4'b1100);
    restore = 1'b0;
    set_in(1'b0, 3'b001, {8'h00, 4'b0110}, {8'h00, 4'b1111});
    tick();
    set_in(1'b0, 3'b000, '0, '0);
    save = 1'b1;
    restore = 1'b1;
    tick();
    chk_all("sr.both", 3'b000, 1'b1, 4'b1100);
    save = 1'b0;
    tick();
    chk_all("sr.after_both", 3'b000, 1'b1, 4'b0110);
    restore = 1'b0;
`endif

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic          fz, sv, rs;
      logic [N-1:0]  rq;
      logic [N*FW-1:0] fl, mk;
      fz = ($urandom_range(0, 5) == 0);
      rq = N'($urandom);
      fl = (N*FW)'($urandom);
      mk = (N*FW)'($urandom);
      sv = SR & ($urandom_range(0, 7) == 0);
      rs = SR & ($urandom_range(0, 9) == 0);
      set_in(fz, rq, fl, mk);
      save    = sv;
      restore = rs;
      model_step(fz, rq, fl, mk, sv, rs);
      tick();
      chk_all($sformatf("rnd%0d", i), exp_gnt, exp_we, m_cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
